tt_um_inverter_probe_siliconeguide: RTL and testbench
=====================================================

Name: tt_um_inverter_probe_SiliconeGuide

Overview:
- Digital stimulus/response tester for the 3.3 V analog inverter tile: the transmit end of its loopback.
- Drives a square-wave test signal out on uo_out[0], which is wired externally to the inverter input.
- Receives the inverter output back on ui_in[0], synchronizes it, and measures per-edge propagation latency in clock cycles.
- Reports busy/done/fail flags and the worst-case latency seen.

Parameters:
- HALF_PERIOD, 16: minimum clock cycles between stimulus edges.
- TIMEOUT, 255: cycles without a correct response before the run fails.
- SYNC_STAGES, 2: flops in the input synchronizer for ui_in[2:0].
- LAT_W, 8: latency counter and max-latency register width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  tile enable; ignored
- ui_in  input  8  [0] response from inverter; [1] start; [2] expect_invert; [7:4] edge count N (0 means 16); [3] unused
- uo_out  output  8  [0] stim; [1] busy; [2] done; [3] fail; [7:4] edges completed (mod 16)
- uio_in  input  8  unused
- uio_out  output  8  max latency observed (saturating)
- uio_oe  output  8  constant 8'hFF

Behaviour:
- Reset state: all outputs 0 except uio_oe=FF. This includes stim, busy, done, fail, edges_done, max_lat and all counters. FSM enters IDLE.
- Input synchronization: ui_in[2:0] each pass through SYNC_STAGES flops. Start is rising-edge detected after synchronization.
- Expected response: stim XOR expect_invert. Default expect_invert=0 matches the double inverter, which is non-inverting.
- IDLE / DONE, on start edge:
  - Clear done, fail, max_lat and edges_done.
  - Latch N and expect_invert.
  - Set busy=1, enter EDGE.
- EDGE (one cycle):
  - Toggle stim.
  - Clear lat_cnt and half_cnt.
  - Enter WAIT.
- WAIT (each cycle):
  - half_cnt and lat_cnt increment. lat_cnt saturates at 2^LAT_W-1.
  - When the synced response equals the expected value:
    - max_lat <= max(max_lat, lat_cnt); increment edges_done.
    - If edges_done reaches N, enter DONE. Otherwise enter HOLD.
  - If lat_cnt == TIMEOUT without a match: fail=1, max_lat=saturated value, enter DONE.
- HOLD:
  - Wait until half_cnt >= HALF_PERIOD-1, then enter EDGE.
  - If already satisfied on entry, go straight to EDGE next cycle.
- DONE: busy=0, done=1. stim holds its last level. fail holds until the next start.
- Latency definition: cycles from the stim register update to the cycle the matching synced response is sampled.
  - Zero-delay external loopback reports SYNC_STAGES (2).
  - An extra D-cycle loopback delay reports 2+D.
- Start edge while busy: ignored.
- Response that matches before the toggle: cannot occur. WAIT compares only after the toggle.
- Response glitching back after the match: not checked in HOLD.
- Asynchronous reset mid-run: immediate return to the reset state. Stim returns to 0 on the pin.
- The N=0 encoding runs 16 edges. edges_done on uo_out[7:4] wraps to 0 at completion of a 16-edge run, with done=1.

Decomposition:
- Shared package: FSM state enum (IDLE, EDGE, WAIT, HOLD, DONE), uo_out bit index constants, and the N-decode constant (0 maps to 16).
- One natural sub-module, inv_probe_sync: a parameterized SYNC_STAGES-deep synchronizer with a rising-edge output. It is instantiated for start, and the plain synced outputs are used for response and expect_invert.

Test Plan:
- Zero-delay non-inverting loopback (ui_in[0]=uo_out[0]), N=4, start pulse -> 4 stim toggles spaced ≥16 cycles; done=1, fail=0, busy=0, uo_out[7:4]=4, uio_out=2.
- Inverting loopback (ui_in[0]=~uo_out[0]) with expect_invert=1, N=0 -> 16 edges; done=1, fail=0, uo_out[7:4]=0, uio_out=2.
- Loopback with 5-cycle delay on edge 3 only, 0 elsewhere, N=6 -> done=1, fail=0, uio_out=7.
- Response tied low, N=4 -> first edge (stim 0→1) times out after 255 cycles; fail=1, done=1, uio_out=255, uo_out[7:4]=0.
- Start re-pulsed mid-run -> run unaffected. Second start after done -> flags and max_lat cleared, new run completes normally.
- rst_n asserted in WAIT -> next observation shows uo_out=0 and uio_out=0 with no clock edge; uio_oe=FF throughout.

Source files
------------

// File: rtl/inv_probe_pkg.sv
// Shared types and constants for the inverter loopback probe.
// FSM states, uo_out/ui_in bit positions and edge-count decode.
package inv_probe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDGE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  localparam int STIM_B = 0;
  localparam int BUSY_B = 1;
  localparam int DONE_B = 2;
  localparam int FAIL_B = 3;

  localparam int RESP_B  = 0;
  localparam int START_B = 1;
  localparam int INV_B   = 2;

  localparam logic [4:0] N_ZERO_MAP = 5'd16;

  function automatic logic [4:0] decode_n(
    input logic [3:0] n
  );
    if (n == 4'd0) return N_ZERO_MAP;
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/inv_probe_if.sv
// Tiny Tapeout style pin bundle of the probe.
// The bench drives the master side, the tile is the slave.
interface inv_probe_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/inv_probe_sync.sv
// Multi-flop input synchronizer for a small bus.
// One selected bit also gets a rising-edge pulse.
module inv_probe_sync #(
  parameter int W        = 3,
  parameter int STAGES   = 2,
  parameter int EDGE_BIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o
);

  logic [STAGES-1:0][W-1:0] sh_q;
  logic                     prev_q;

  // shift the raw inputs through the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sh_q[i] <= sh_q[i-1];
      end
    end
  end

  // remember last synced level of the edge bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sh_q[STAGES-1][EDGE_BIT];
  end

  assign q_o    = sh_q[STAGES-1];
  assign rise_o = q_o[EDGE_BIT] & ~prev_q;

endmodule

// File: rtl/tt_um_inverter_probe_siliconeguide.sv
// Stimulus/response tester for the analog inverter tile.
// Toggles stim, waits for the looped-back echo, logs worst latency.
module tt_um_inverter_probe_siliconeguide
  import inv_probe_pkg::*;
#(
  parameter int HALF_PERIOD = 16,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2,
  parameter int LAT_W       = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  inv_probe_if.slave io
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] TMO_C   = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] HOLD_C  = LAT_W'(HALF_PERIOD - 1);

  logic [2:0] sync_s;
  logic       start_rise;

  inv_probe_sync #(
    .W       (3),
    .STAGES  (SYNC_STAGES),
    .EDGE_BIT(START_B)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (io.ui_in[2:0]),
    .q_o   (sync_s),
    .rise_o(start_rise)
  );

  state_e           state_q, state_d;
  logic             stim_q, stim_d;
  logic             fail_q, fail_d;
  logic             inv_q, inv_d;
  logic [4:0]       n_q, n_d;
  logic [4:0]       edges_q, edges_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] half_q, half_d;
  logic [LAT_W-1:0] max_q, max_d;

  logic       resp_ok;
  logic [4:0] edges_inc;
  logic       busy, done;

  assign resp_ok   = sync_s[RESP_B] == (stim_q ^ inv_q);
  assign edges_inc = edges_q + 5'd1;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= 1'b0;
      fail_q  <= 1'b0;
      inv_q   <= 1'b0;
      n_q     <= '0;
      edges_q <= '0;
      lat_q   <= '0;
      half_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      fail_q  <= fail_d;
      inv_q   <= inv_d;
      n_q     <= n_d;
      edges_q <= edges_d;
      lat_q   <= lat_d;
      half_q  <= half_d;
      max_q   <= max_d;
    end
  end

  // sequencing: toggle, wait for echo, hold half period
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    fail_d  = fail_q;
    inv_d   = inv_q;
    n_d     = n_q;
    edges_d = edges_q;
    lat_d   = lat_q;
    half_d  = half_q;
    max_d   = max_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          fail_d  = 1'b0;
          max_d   = '0;
          edges_d = '0;
          n_d     = decode_n(io.ui_in[7:4]);
          inv_d   = sync_s[INV_B];
          state_d = S_EDGE;
        end
      end
      S_EDGE: begin
        stim_d  = ~stim_q;
        lat_d   = '0;
        half_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q != LAT_MAX) lat_d = lat_q + 1'b1;
        if (half_q != LAT_MAX) half_d = half_q + 1'b1;
        if (resp_ok) begin
          if (lat_q > max_q) max_d = lat_q;
          edges_d = edges_inc;
          if (edges_inc == n_q) state_d = S_DONE;
          else                  state_d = S_HOLD;
        end else if (lat_q == TMO_C) begin
          fail_d  = 1'b1;
          max_d   = LAT_MAX;
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (half_q != LAT_MAX) half_d = half_q + 1'b1;
        if (half_q >= HOLD_C) state_d = S_EDGE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_EDGE) ||
                (state_q == S_WAIT) ||
                (state_q == S_HOLD);
  assign done = state_q == S_DONE;

  assign io.uo_out  = {edges_q[3:0], fail_q, done, busy, stim_q};
  assign io.uio_out = max_q;
  assign io.uio_oe  = 8'hFF;

  logic _unused;
  assign _unused = &{1'b0, io.ena, io.uio_in,
                     io.ui_in[3], sync_s[START_B], edges_q[4]};

endmodule

// File: tb/tb_tt_um_inverter_probe_siliconeguide.sv
// Self-checking bench for the inverter loopback probe.
// Loopback model sits between uo_out[0] and ui_in[0].
module tb_tt_um_inverter_probe_siliconeguide;

  typedef struct {
    bit         fail;
    logic [3:0] edges;
    logic [7:0] lat;
    int         tog;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_probe_if bus ();

  tt_um_inverter_probe_siliconeguide dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  logic       start = 1'b0;
  logic       inv_sel = 1'b0;
  logic [3:0] n_sel = 4'd0;
  int         mode = 0;
  logic       resp;
  logic [7:0] dly = '0;

  int vectors = 0;
  int miscompares = 0;
  exp_t sbq[$];

  // loopback: 0 straight, 1 inverted, 2 tied low, 3 delay 5 on edge 3
  always @(posedge clk) dly <= {dly[6:0], bus.uo_out[0]};

  always_comb begin
    resp = bus.uo_out[0];
    case (mode)
      1: resp = ~bus.uo_out[0];
      2: resp = 1'b0;
      3: resp = (bus.uo_out[7:4] == 4'd2) ? dly[4] : bus.uo_out[0];
      default: resp = bus.uo_out[0];
    endcase
  end

  assign bus.ui_in  = {n_sel, 1'b0, inv_sel, start, resp};
  assign bus.ena    = 1'b1;
  assign bus.uio_in = 8'h00;

  // stim edge monitor: count toggles, flag edges closer than 16
  int   tog = 0;
  int   since = 1000;
  int   gap_bad = 0;
  logic stim_prev = 1'b0;
  always @(posedge clk) begin
    if (bus.uo_out[0] !== stim_prev) begin
      tog = tog + 1;
      if (since < 16) gap_bad = gap_bad + 1;
      since = 0;
    end else if (since < 1000) begin
      since = since + 1;
    end
    stim_prev = bus.uo_out[0];
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.uo_out[2] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_uo got %h want 00", bus.uo_out);
    end
    vectors++;
    if (bus.uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_uio got %h want 00", bus.uio_out);
    end
    vectors++;
    if (bus.uio_oe !== 8'hFF) begin
      miscompares++;
      $display("FAIL rst_oe got %h want FF", bus.uio_oe);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_loop();
    exp_t e;
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 0; inv_sel = 1'b0; n_sel = 4'd4;
    base = tog;
    sbq.push_back('{fail: 1'b0, edges: 4'd4, lat: 8'd2, tog: 4});
    pulse_start();
    wait_done(2000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_done got 0 want 1");
    end
    vectors++;
    if (bus.uo_out[3:1] !== {g.fail, 2'b10}) begin
      miscompares++;
      $display("FAIL basic_flags got %b want %b",
               bus.uo_out[3:1], {g.fail, 2'b10});
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges) begin
      miscompares++;
      $display("FAIL basic_edges got %0d want %0d",
               bus.uo_out[7:4], g.edges);
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL basic_lat got %0d want %0d", bus.uio_out, g.lat);
    end
    vectors++;
    if (tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL basic_tog got %0d want %0d", tog - base, g.tog);
    end
    e = g;
  endtask

  task automatic test_inverted_n16();
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 1; inv_sel = 1'b1; n_sel = 4'd0;
    base = tog;
    sbq.push_back('{fail: 1'b0, edges: 4'd0, lat: 8'd2, tog: 16});
    pulse_start();
    wait_done(3000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL inv_done got 0 want 1");
    end
    vectors++;
    if (bus.uo_out[3:1] !== {g.fail, 2'b10}) begin
      miscompares++;
      $display("FAIL inv_flags got %b want %b",
               bus.uo_out[3:1], {g.fail, 2'b10});
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges) begin
      miscompares++;
      $display("FAIL inv_edges got %0d want %0d",
               bus.uo_out[7:4], g.edges);
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL inv_lat got %0d want %0d", bus.uio_out, g.lat);
    end
    vectors++;
    if (tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL inv_tog got %0d want %0d", tog - base, g.tog);
    end
    inv_sel = 1'b0;
  endtask

  task automatic test_delay_edge3();
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 3; inv_sel = 1'b0; n_sel = 4'd6;
    base = tog;
    sbq.push_back('{fail: 1'b0, edges: 4'd6, lat: 8'd7, tog: 6});
    pulse_start();
    wait_done(2000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok || bus.uo_out[3] !== g.fail) begin
      miscompares++;
      $display("FAIL dly_flags got done=%0d fail=%0d want 1/%0d",
               ok, bus.uo_out[3], g.fail);
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL dly_lat got %0d want %0d", bus.uio_out, g.lat);
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges || tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL dly_edges got %0d/%0d want %0d/%0d",
               bus.uo_out[7:4], tog - base, g.edges, g.tog);
    end
  endtask

  task automatic test_restart_midrun();
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 0; inv_sel = 1'b0; n_sel = 4'd4;
    base = tog;
    sbq.push_back('{fail: 1'b0, edges: 4'd4, lat: 8'd2, tog: 4});
    pulse_start();
    repeat (25) @(negedge clk);
    pulse_start();
    wait_done(2000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok || bus.uo_out[3] !== g.fail) begin
      miscompares++;
      $display("FAIL rst_mid_flags got done=%0d fail=%0d want 1/%0d",
               ok, bus.uo_out[3], g.fail);
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges || tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL restart_edges got %0d/%0d want %0d/%0d",
               bus.uo_out[7:4], tog - base, g.edges, g.tog);
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL restart_lat got %0d want %0d", bus.uio_out, g.lat);
    end
  endtask

  task automatic test_timeout();
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 2; inv_sel = 1'b0; n_sel = 4'd4;
    base = tog;
    sbq.push_back('{fail: 1'b1, edges: 4'd0, lat: 8'd255, tog: 1});
    pulse_start();
    wait_done(2000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL tmo_done got 0 want 1");
    end
    vectors++;
    if (bus.uo_out[3:1] !== {g.fail, 2'b10}) begin
      miscompares++;
      $display("FAIL tmo_flags got %b want %b",
               bus.uo_out[3:1], {g.fail, 2'b10});
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL tmo_lat got %0d want %0d", bus.uio_out, g.lat);
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges || tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL tmo_edges got %0d/%0d want %0d/%0d",
               bus.uo_out[7:4], tog - base, g.edges, g.tog);
    end
  endtask

  task automatic test_back_to_back();
    exp_t g;
    bit   ok;
    int   base;
    repeat (20) @(negedge clk);
    mode = 0; inv_sel = 1'b0; n_sel = 4'd3;
    base = tog;
    sbq.push_back('{fail: 1'b0, edges: 4'd3, lat: 8'd2, tog: 3});
    pulse_start();
    vectors++;
    if (bus.uo_out[3:1] !== 3'b001 || bus.uio_out !== 8'h00 ||
        bus.uo_out[7:4] !== 4'd0) begin
      miscompares++;
      $display("FAIL clear got fdb=%b lat=%0d edg=%0d want 001/0/0",
               bus.uo_out[3:1], bus.uio_out, bus.uo_out[7:4]);
    end
    wait_done(2000, ok);
    g = sbq.pop_front();
    vectors++;
    if (!ok || bus.uo_out[3] !== g.fail) begin
      miscompares++;
      $display("FAIL b2b_flags got done=%0d fail=%0d want 1/%0d",
               ok, bus.uo_out[3], g.fail);
    end
    vectors++;
    if (bus.uio_out !== g.lat) begin
      miscompares++;
      $display("FAIL b2b_lat got %0d want %0d", bus.uio_out, g.lat);
    end
    vectors++;
    if (bus.uo_out[7:4] !== g.edges || tog - base !== g.tog) begin
      miscompares++;
      $display("FAIL b2b_edges got %0d/%0d want %0d/%0d",
               bus.uo_out[7:4], tog - base, g.edges, g.tog);
    end
    vectors++;
    if (gap_bad !== 0) begin
      miscompares++;
      $display("FAIL edge_gap got %0d short gaps want 0", gap_bad);
    end
  endtask

  task automatic test_async_reset();
    repeat (20) @(negedge clk);
    mode = 2; inv_sel = 1'b0; n_sel = 4'd4;
    pulse_start();
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.uo_out[1:0] !== 2'b11) begin
      miscompares++;
      $display("FAIL arst_pre got %b want 11", bus.uo_out[1:0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL arst got uo=%h uio=%h want 00/00",
               bus.uo_out, bus.uio_out);
    end
    vectors++;
    if (bus.uio_oe !== 8'hFF) begin
      miscompares++;
      $display("FAIL arst_oe got %h want FF", bus.uio_oe);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_inverted_n16();
    test_delay_edge3();
    test_restart_midrun();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
